dispatch_queue: RTL and testbench
=================================

// Module: dispatch_queue
// PURPOSE
//  In-order buffer between rename and inst_router. Holds renamed instructions, snoops PRN-ready broadcasts
//  to refresh per-operand ready bits, and issues the head to inst_router when the selected FU queue has space.
//  Absorbs FU-queue back-pressure so rename can keep producing.
// PARAMETERS
//  INST_ID_BITS  6  instruction-id width
//  PRN_BITS      6  physical register number width
//  MAX_OPERANDS  3  source/destination operand slots per instruction
//  FU_COUNT      4  functional units (0 logical, 1 LSU, 2 arith, 3 DPI)
//  FUC_BITS      2  FU-select width, 2**FUC_BITS >= FU_COUNT
//  DEPTH         8  entries; power of two, >= 2
// PORTS
//  clk                   in   1             clock, all state on rising edge
//  rst                   in   1             asynchronous, active-high reset
//  flush                 in   1             sync: drop all buffered entries
//  in_valid              in   1             rename offers an instruction
//  in_ready              out  1             queue accepts this cycle
//  in_inst_id            in   INST_ID_BITS  instruction id
//  in_raw_instr          in   32            encoding
//  in_instr_pc           in   64            PC
//  in_fu_choice          in   FUC_BITS      target FU
//  in_prn_input_valid    in   [MAX_OPERANDS]x1         source slot used
//  in_prn_input_ready    in   [MAX_OPERANDS]x1         source value available at rename
//  in_prn_input          in   [MAX_OPERANDS]xPRN_BITS  source PRNs
//  in_prn_output_valid   in   [MAX_OPERANDS]x1         dest slot used
//  in_prn_output         in   [MAX_OPERANDS]xPRN_BITS  dest PRNs
//  set_prn_ready         in   [FU_COUNT][MAX_OPERANDS]x1         writeback broadcast valid
//  set_prn               in   [FU_COUNT][MAX_OPERANDS]xPRN_BITS  writeback broadcast PRN
//  queue_ready           in   [FU_COUNT]x1  FU queue has space
//  out_inst_valid, out_inst_id, out_raw_instr, out_instr_pc, out_fu_choice, out_prn_input_valid,
//  out_prn_input_ready, out_prn_input, out_prn_output_valid, out_prn_output
//                        out  same widths as in_*  head entry to inst_router
//  occupancy             out  $clog2(DEPTH)+1      entries held
// BEHAVIOUR
//  - Reset: head=tail=0, occupancy=0, all entries invalid; in_ready=1, out_inst_valid=0. Reset mid-op drops all.
//  - Circular FIFO, head/tail wrap modulo DEPTH. in_ready = (occupancy != DEPTH) && !flush.
//  - Enqueue when in_valid && in_ready; entry written at tail, tail++.
//  - Dispatch (combinational, 0-cycle from head): out_inst_valid = (occupancy!=0) && queue_ready[head.fu_choice]
//    && !flush. out_* always driven from head entry; ignored by consumer when out_inst_valid=0.
//    When out_inst_valid=1 the head pops at the clock edge (head++). One issue per cycle max.
//  - in_fu_choice >= FU_COUNT: entry blocks forever (treated as queue_ready=0); rename never generates it.
//  - Wakeup: for each stored entry and source j with prn_input_valid[j]: ready[j] set at edge if any
//    set_prn_ready[f][k] && set_prn[f][k]==prn_input[j]. Ready bits never clear while buffered.
//  - Bypass: out_prn_input_ready[j] = stored ready[j] OR same-cycle matching broadcast.
//  - Enqueue-time wakeup: an entry enqueued in the same cycle as a matching broadcast is stored ready=1.
//  - Dispatch ignores operand readiness (FU queues wait on operands); it only gates on queue_ready.
//  - Simultaneous enqueue+dispatch: occupancy unchanged. Full queue: in_ready=0, dispatch still allowed
//    (space seen next cycle). Empty: dispatch impossible; no fall-through of in_* to out_* in same cycle.
//  - flush: no enqueue or dispatch that cycle; next cycle occupancy=0, head=tail=0.
// TESTING
//  1 Reset then 3 enqueues (ids 1,2,3, fu 2), queue_ready[2]=1 -> out ids 1,2,3 on consecutive cycles, occupancy 0 after.
//  2 Fill 8 entries with queue_ready all 0 -> in_ready=0, occupancy=8; raise queue_ready[0] (all fu 0) -> drain 8, tail/head wrap to 0.
//  3 Buffered entry src PRN 17 ready=0; set_prn_ready[3][1]=1,set_prn[3][1]=17 -> out_prn_input_ready[j]=1 same cycle and stays 1.
//  4 Enqueue src PRN 5 ready=0 in same cycle as broadcast of PRN 5 -> entry dispatched later with ready=1.
//  5 Head fu 1 with queue_ready[1]=0, queue_ready[2]=1 -> no issue (in-order); head not bypassed by fu-2 entry behind it.
//  6 occupancy=5, flush=1 with in_valid=1 -> in_ready=0, out_inst_valid=0; next cycle occupancy=0. Async rst mid-drain -> out_inst_valid=0 immediately.

Source files
------------

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order dispatch buffer between rename and inst_router with operand wakeup snooping
module dispatch_queue #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int FUC_BITS     = 2,
    parameter int DEPTH        = 8
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               flush,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [INST_ID_BITS-1:0]                            in_inst_id,
    input  logic [31:0]                                        in_raw_instr,
    input  logic [63:0]                                        in_instr_pc,
    input  logic [FUC_BITS-1:0]                                in_fu_choice,
    input  logic [MAX_OPERANDS-1:0]                            in_prn_input_valid,
    input  logic [MAX_OPERANDS-1:0]                            in_prn_input_ready,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              in_prn_input,
    input  logic [MAX_OPERANDS-1:0]                            in_prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              in_prn_output,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]              set_prn_ready,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    input  logic [FU_COUNT-1:0]                                queue_ready,
    output logic                                               out_inst_valid,
    output logic [INST_ID_BITS-1:0]                            out_inst_id,
    output logic [31:0]                                        out_raw_instr,
    output logic [63:0]                                        out_instr_pc,
    output logic [FUC_BITS-1:0]                                out_fu_choice,
    output logic [MAX_OPERANDS-1:0]                            out_prn_input_valid,
    output logic [MAX_OPERANDS-1:0]                            out_prn_input_ready,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              out_prn_input,
    output logic [MAX_OPERANDS-1:0]                            out_prn_output_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              out_prn_output,
    output logic [$clog2(DEPTH):0]                             occupancy
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [INST_ID_BITS-1:0]               id_q   [DEPTH];
    logic [31:0]                           raw_q  [DEPTH];
    logic [63:0]                           pc_q   [DEPTH];
    logic [FUC_BITS-1:0]                   fu_q   [DEPTH];
    logic [MAX_OPERANDS-1:0]               srcv_q [DEPTH];
    logic [MAX_OPERANDS-1:0]               rdy_q  [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src_q  [DEPTH];
    logic [MAX_OPERANDS-1:0]               dstv_q [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst_q  [DEPTH];

    logic [PTR_BITS-1:0]     head, tail;
    logic [CNT_BITS-1:0]     count;
    logic                    head_fu_ok;
    logic                    push, pop;
    logic [MAX_OPERANDS-1:0] in_rdy_eff;

    function automatic logic bcast_hit(
        input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               v,
        input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] p,
        input logic [PRN_BITS-1:0]                                 prn
    );
        logic h;
        h = 1'b0;
        for (int f = 0; f < FU_COUNT; f++)
            for (int k = 0; k < MAX_OPERANDS; k++)
                h = h | (v[f][k] && (p[f][k] == prn));
        return h;
    endfunction

    // FU selects beyond FU_COUNT match no queue and therefore never issue
    always_comb begin
        head_fu_ok = 1'b0;
        for (int f = 0; f < FU_COUNT; f++)
            if (fu_q[head] == FUC_BITS'(f))
                head_fu_ok = queue_ready[f];
    end

    assign in_ready       = (count != CNT_BITS'(DEPTH)) && !flush;
    assign out_inst_valid = (count != '0) && head_fu_ok && !flush;
    assign push           = in_valid && in_ready;
    assign pop            = out_inst_valid;
    assign occupancy      = count;

    always_comb begin
        in_rdy_eff          = '0;
        out_prn_input_ready = '0;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            in_rdy_eff[j] = in_prn_input_ready[j] |
                (in_prn_input_valid[j] & bcast_hit(set_prn_ready, set_prn, in_prn_input[j]));
            out_prn_input_ready[j] = rdy_q[head][j] |
                (srcv_q[head][j] & bcast_hit(set_prn_ready, set_prn, src_q[head][j]));
        end
    end

    assign out_inst_id          = id_q[head];
    assign out_raw_instr        = raw_q[head];
    assign out_instr_pc         = pc_q[head];
    assign out_fu_choice        = fu_q[head];
    assign out_prn_input_valid  = srcv_q[head];
    assign out_prn_input        = src_q[head];
    assign out_prn_output_valid = dstv_q[head];
    assign out_prn_output       = dst_q[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Payload needs no reset: occupancy alone decides which slots are live
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < MAX_OPERANDS; j++)
                if (srcv_q[i][j] && bcast_hit(set_prn_ready, set_prn, src_q[i][j]))
                    rdy_q[i][j] <= 1'b1;
        if (push) begin
            id_q[tail]   <= in_inst_id;
            raw_q[tail]  <= in_raw_instr;
            pc_q[tail]   <= in_instr_pc;
            fu_q[tail]   <= in_fu_choice;
            srcv_q[tail] <= in_prn_input_valid;
            rdy_q[tail]  <= in_rdy_eff;
            src_q[tail]  <= in_prn_input;
            dstv_q[tail] <= in_prn_output_valid;
            dst_q[tail]  <= in_prn_output;
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - directed plus randomized checking of dispatch_queue against a queue-based model
module tb_dispatch_queue;
    localparam int D = 8;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready;
    logic [5:0]       in_inst_id;
    logic [31:0]      in_raw_instr;
    logic [63:0]      in_instr_pc;
    logic [1:0]       in_fu_choice;
    logic [2:0]       in_prn_input_valid, in_prn_input_ready, in_prn_output_valid;
    logic [2:0][5:0]  in_prn_input, in_prn_output;
    logic [3:0][2:0]  set_prn_ready;
    logic [3:0][2:0][5:0] set_prn;
    logic [3:0]       queue_ready;
    logic             out_inst_valid;
    logic [5:0]       out_inst_id;
    logic [31:0]      out_raw_instr;
    logic [63:0]      out_instr_pc;
    logic [1:0]       out_fu_choice;
    logic [2:0]       out_prn_input_valid, out_prn_input_ready, out_prn_output_valid;
    logic [2:0][5:0]  out_prn_input, out_prn_output;
    logic [3:0]       occupancy;

    dispatch_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_instr_pc(in_instr_pc),
        .in_fu_choice(in_fu_choice), .in_prn_input_valid(in_prn_input_valid),
        .in_prn_input_ready(in_prn_input_ready), .in_prn_input(in_prn_input),
        .in_prn_output_valid(in_prn_output_valid), .in_prn_output(in_prn_output),
        .set_prn_ready(set_prn_ready), .set_prn(set_prn), .queue_ready(queue_ready),
        .out_inst_valid(out_inst_valid), .out_inst_id(out_inst_id), .out_raw_instr(out_raw_instr),
        .out_instr_pc(out_instr_pc), .out_fu_choice(out_fu_choice),
        .out_prn_input_valid(out_prn_input_valid), .out_prn_input_ready(out_prn_input_ready),
        .out_prn_input(out_prn_input), .out_prn_output_valid(out_prn_output_valid),
        .out_prn_output(out_prn_output), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]      id;
        logic [31:0]     raw;
        logic [63:0]     pc;
        logic [1:0]      fu;
        logic [2:0]      sv, sr, dv;
        logic [2:0][5:0] sp, dp;
    } ent_t;

    ent_t mq[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input logic [5:0] p);
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 3; k++)
                if (set_prn_ready[f][k] && set_prn[f][k] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_valid();
        if (mq.size() == 0 || flush) return 1'b0;
        return queue_ready[mq[0].fu];
    endfunction

    task automatic check_outputs();
        ent_t e;
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'((mq.size() != D) && !flush));
        chk("out_inst_valid", 64'(out_inst_valid), 64'(exp_valid()));
        if (mq.size() != 0) begin
            e = mq[0];
            chk("out_inst_id", 64'(out_inst_id), 64'(e.id));
            chk("out_raw_instr", 64'(out_raw_instr), 64'(e.raw));
            chk("out_instr_pc", out_instr_pc, e.pc);
            chk("out_fu_choice", 64'(out_fu_choice), 64'(e.fu));
            chk("out_prn_input_valid", 64'(out_prn_input_valid), 64'(e.sv));
            chk("out_prn_input", 64'(out_prn_input), 64'(e.sp));
            chk("out_prn_output_valid", 64'(out_prn_output_valid), 64'(e.dv));
            chk("out_prn_output", 64'(out_prn_output), 64'(e.dp));
            for (int j = 0; j < 3; j++)
                chk("out_prn_input_ready", 64'(out_prn_input_ready[j]),
                    64'(e.sr[j] | (e.sv[j] & hit(e.sp[j]))));
        end
    endtask

    task automatic model_update();
        logic pop_it, push_it;
        ent_t t;
        pop_it  = exp_valid();
        push_it = in_valid && (mq.size() != D) && !flush;
        if (flush) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                t = mq[i];
                for (int j = 0; j < 3; j++)
                    if (t.sv[j] && hit(t.sp[j])) t.sr[j] = 1'b1;
                mq[i] = t;
            end
            if (pop_it) void'(mq.pop_front());
            if (push_it) begin
                t.id = in_inst_id; t.raw = in_instr_pc[31:0] ^ 32'h0; t.raw = in_raw_instr;
                t.pc = in_instr_pc; t.fu = in_fu_choice;
                t.sv = in_prn_input_valid; t.sp = in_prn_input;
                t.dv = in_prn_output_valid; t.dp = in_prn_output;
                for (int j = 0; j < 3; j++)
                    t.sr[j] = in_prn_input_ready[j] | (in_prn_input_valid[j] & hit(in_prn_input[j]));
                mq.push_back(t);
            end
        end
    endtask

    task automatic cyc();
        #4;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; set_prn_ready = '0;
    endtask

    task automatic enq(input logic [5:0] id, input logic [1:0] fu, input logic [2:0] sv,
                       input logic [2:0] sr, input logic [5:0] sp0);
        in_valid = 1'b1; in_inst_id = id; in_fu_choice = fu;
        in_raw_instr = $urandom; in_instr_pc = {$urandom, $urandom};
        in_prn_input_valid = sv; in_prn_input_ready = sr;
        in_prn_input = {6'($urandom_range(20, 40)), 6'($urandom_range(20, 40)), sp0};
        in_prn_output_valid = 3'($urandom); in_prn_output = 18'($urandom);
    endtask

    initial begin
        rst = 1'b1; idle(); queue_ready = '0; set_prn = '0;
        enq(6'd0, 2'd0, 3'd0, 3'd0, 6'd0); in_valid = 1'b0;
        #3;
        mq.delete();
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_inst_valid), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // three in-order issues to FU 2
        queue_ready = 4'b0100;
        for (int i = 1; i <= 3; i++) begin enq(6'(i), 2'd2, 3'b000, 3'b000, 6'd0); cyc(); end
        idle();
        repeat (4) cyc();
        chk("t1_empty", 64'(occupancy), 64'd0);

        // fill to full, then drain through FU 0 with pointer wrap
        queue_ready = 4'b0000;
        for (int i = 0; i < 9; i++) begin enq(6'(10 + i), 2'd0, 3'b011, 3'b000, 6'd9); cyc(); end
        chk("t2_full_in_ready", 64'(in_ready), 64'd0);
        chk("t2_full_occ", 64'(occupancy), 64'd8);
        idle(); queue_ready = 4'b0001;
        repeat (8) cyc();
        chk("t2_drained", 64'(occupancy), 64'd0);
        enq(6'd33, 2'd0, 3'b000, 3'b000, 6'd0); cyc(); idle(); cyc();

        // stored wakeup with same-cycle bypass
        queue_ready = 4'b0000;
        enq(6'd40, 2'd3, 3'b001, 3'b000, 6'd17); cyc();
        idle(); set_prn_ready[3][1] = 1'b1; set_prn[3][1] = 6'd17;
        #1 chk("t3_bypass", 64'(out_prn_input_ready[0]), 64'd1);
        cyc();
        idle(); set_prn = '0;
        chk("t3_stays", 64'(out_prn_input_ready[0]), 64'd1);
        cyc();
        flush = 1'b1; cyc(); idle();

        // enqueue-time wakeup
        enq(6'd41, 2'd2, 3'b001, 3'b000, 6'd5);
        set_prn_ready[0][0] = 1'b1; set_prn[0][0] = 6'd5; cyc();
        idle(); set_prn = '0; cyc();
        chk("t4_ready", 64'(out_prn_input_ready[0]), 64'd1);
        queue_ready = 4'b0100; cyc(); cyc();

        // in-order blocking: FU1 head stalls the FU2 entry behind it
        queue_ready = 4'b0100;
        enq(6'd50, 2'd1, 3'b000, 3'b000, 6'd0); cyc();
        enq(6'd51, 2'd2, 3'b000, 3'b000, 6'd0); cyc();
        idle(); cyc();
        chk("t5_blocked", 64'(out_inst_valid), 64'd0);
        chk("t5_head", 64'(out_inst_id), 64'd50);

        // flush with a pending enqueue
        queue_ready = 4'b0000; flush = 1'b1; cyc(); idle();
        for (int i = 0; i < 5; i++) begin enq(6'(60 + i), 2'(i), 3'b000, 3'b000, 6'd0); cyc(); end
        flush = 1'b1; enq(6'd7, 2'd0, 3'b000, 3'b000, 6'd0); flush = 1'b1;
        #1 chk("t6_flush_in_ready", 64'(in_ready), 64'd0);
        chk("t6_flush_out_valid", 64'(out_inst_valid), 64'd0);
        cyc(); idle();
        chk("t6_flush_occ", 64'(occupancy), 64'd0);

        // asynchronous reset in the middle of a drain
        queue_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin enq(6'(70 + i), 2'd3, 3'b000, 3'b000, 6'd0); cyc(); end
        idle(); cyc();
        #2 rst = 1'b1;
        #1 chk("t6_rst_out_valid", 64'(out_inst_valid), 64'd0);
        chk("t6_rst_occ", 64'(occupancy), 64'd0);
        mq.delete();
        @(posedge clk); #1; rst = 1'b0;

        // randomized traffic
        repeat (400) begin
            in_valid = ($urandom_range(0, 3) != 0);
            enq(6'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 6'($urandom_range(0, 15)));
            in_valid = ($urandom_range(0, 3) != 0);
            queue_ready = 4'($urandom);
            flush = ($urandom_range(0, 29) == 0);
            for (int f = 0; f < 4; f++)
                for (int k = 0; k < 3; k++) begin
                    set_prn_ready[f][k] = ($urandom_range(0, 5) == 0);
                    set_prn[f][k] = 6'($urandom_range(0, 15));
                end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
